// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch PC with a small FIFO buffer feeding decode
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic                   deq,
  output logic                   valid,
  output logic [31:0]            ins_out,
  output logic [XLEN-1:0]        pc_out,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      ins_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q  [DEPTH];

  logic            empty;
  logic            is_full;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] pc_next;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CNT_FULL);
  assign pc_next = pc_q + PC_STEP;

  // A full queue may still accept a fetch when decode frees the head in the same cycle.
  assign push = fetch_en & ~redirect & (~is_full | deq);
  assign pop  = deq & ~empty & ~redirect;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_next;
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; slots are only observed while occupied.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ins_mem_q[tail_q] <= imem_data;
      pc_mem_q[tail_q]  <= pc_next;
    end
  end

  assign imem_addr = pc_q;
  assign valid     = ~empty;
  assign full      = is_full;
  assign count     = count_q;
  assign ins_out   = empty ? 32'h0 : ins_mem_q[head_q];
  assign pc_out    = empty ? '0 : pc_mem_q[head_q];

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (default and 8-bit wrap instances)
module tb_fetch_queue;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  // Instance A: default parameters
  logic        rst_a, fetch_en_a, redirect_a, deq_a;
  logic [31:0] imem_addr_a, imem_data_a, redirect_pc_a, ins_out_a, pc_out_a;
  logic        valid_a, full_a;
  logic [2:0]  count_a;

  assign imem_data_a = 32'hAAAA0000 + imem_addr_a;

  fetch_queue dut_a (
    .clk(clk), .rst(rst_a), .fetch_en(fetch_en_a), .imem_addr(imem_addr_a),
    .imem_data(imem_data_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
    .deq(deq_a), .valid(valid_a), .ins_out(ins_out_a), .pc_out(pc_out_a),
    .full(full_a), .count(count_a)
  );

  // Instance B: 8-bit address space starting near the top to exercise wrap
  logic        rst_b, fetch_en_b, redirect_b, deq_b;
  logic [7:0]  imem_addr_b, redirect_pc_b, pc_out_b;
  logic [31:0] imem_data_b, ins_out_b;
  logic        valid_b, full_b;
  logic [2:0]  count_b;

  assign imem_data_b = {24'hBBBB00, imem_addr_b};

  fetch_queue #(.XLEN(8), .DEPTH(4), .RESET_PC(8'hF8), .PC_STEP(8'd4)) dut_b (
    .clk(clk), .rst(rst_b), .fetch_en(fetch_en_b), .imem_addr(imem_addr_b),
    .imem_data(imem_data_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
    .deq(deq_b), .valid(valid_b), .ins_out(ins_out_b), .pc_out(pc_out_b),
    .full(full_b), .count(count_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    exp_b.push_back(e);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst_a && !redirect_a && deq_a && valid_a) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_a: unexpected pop ins=0x%0h pc=0x%0h, none expected", ins_out_a, pc_out_a);
      end else begin
        e = exp_a.pop_front();
        chk("pop_ins_a", ins_out_a, e.ins);
        chk("pop_pc_a", pc_out_a, e.pc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst_b && !redirect_b && deq_b && valid_b) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_b: unexpected pop ins=0x%0h pc=0x%0h, none expected", ins_out_b, pc_out_b);
      end else begin
        e = exp_b.pop_front();
        chk("pop_ins_b", ins_out_b, e.ins);
        chk("pop_pc_b", 32'(pc_out_b), e.pc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b1; fetch_en_a = 1'b0; redirect_a = 1'b0; deq_a = 1'b0; redirect_pc_a = '0;
    rst_b = 1'b1; fetch_en_b = 1'b0; redirect_b = 1'b0; deq_b = 1'b0; redirect_pc_b = '0;
    tick();
    tick();
    chk("rst_addr_a", imem_addr_a, 32'h0);
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_valid_a", 32'(valid_a), 32'd0);
    chk("rst_full_a", 32'(full_a), 32'd0);
    chk("rst_ins_a", ins_out_a, 32'h0);
    chk("rst_pc_a", pc_out_a, 32'h0);
    chk("rst_addr_b", 32'(imem_addr_b), 32'hF8);

    // Fill from reset
    rst_a = 1'b0; rst_b = 1'b0; fetch_en_a = 1'b1;
    tick();
    chk("fill1_count", 32'(count_a), 32'd1);
    chk("fill1_addr", imem_addr_a, 32'h4);
    tick(); tick(); tick();
    chk("fill_full", 32'(full_a), 32'd1);
    chk("fill_count", 32'(count_a), 32'd4);
    chk("fill_addr", imem_addr_a, 32'h10);
    chk("fill_ins", ins_out_a, 32'hAAAA0000);
    chk("fill_pc", pc_out_a, 32'h4);

    // Full with no dequeue: nothing moves
    tick();
    chk("stall_count", 32'(count_a), 32'd4);
    chk("stall_addr", imem_addr_a, 32'h10);

    // Full with simultaneous dequeue
    push_a(32'hAAAA0000, 32'h4);
    deq_a = 1'b1;
    tick();
    chk("fulldeq_count", 32'(count_a), 32'd4);
    chk("fulldeq_addr", imem_addr_a, 32'h14);
    chk("fulldeq_ins", ins_out_a, 32'hAAAA0004);
    chk("fulldeq_pc", pc_out_a, 32'h8);

    // Pop only with fetch disabled: PC holds
    push_a(32'hAAAA0004, 32'h8);
    fetch_en_a = 1'b0;
    tick();
    chk("hold_count", 32'(count_a), 32'd3);
    chk("hold_addr", imem_addr_a, 32'h14);
    chk("hold_pc", pc_out_a, 32'hC);

    // Redirect with deq asserted: flush, no pop
    redirect_a = 1'b1; redirect_pc_a = 32'h100; fetch_en_a = 1'b1; deq_a = 1'b1;
    tick();
    chk("redir_count", 32'(count_a), 32'd0);
    chk("redir_valid", 32'(valid_a), 32'd0);
    chk("redir_addr", imem_addr_a, 32'h100);
    chk("redir_ins", ins_out_a, 32'h0);
    redirect_a = 1'b0; deq_a = 1'b0;
    tick();
    chk("redir1_count", 32'(count_a), 32'd1);
    chk("redir1_ins", ins_out_a, 32'hAAAA0100);
    chk("redir1_pc", pc_out_a, 32'h104);
    chk("redir1_addr", imem_addr_a, 32'h104);

    // Mid-operation reset, then underflow attempt
    rst_a = 1'b1;
    tick();
    chk("rst2_count", 32'(count_a), 32'd0);
    chk("rst2_addr", imem_addr_a, 32'h0);
    rst_a = 1'b0; fetch_en_a = 1'b0; deq_a = 1'b1;
    tick();
    chk("under_count", 32'(count_a), 32'd0);
    chk("under_valid", 32'(valid_a), 32'd0);
    chk("under_addr", imem_addr_a, 32'h0);

    // Steady stream from empty
    push_a(32'hAAAA0000, 32'h4);
    push_a(32'hAAAA0004, 32'h8);
    push_a(32'hAAAA0008, 32'hC);
    fetch_en_a = 1'b1;
    tick();
    chk("stream1_count", 32'(count_a), 32'd1);
    chk("stream1_pc", pc_out_a, 32'h4);
    tick();
    chk("stream2_count", 32'(count_a), 32'd1);
    chk("stream2_pc", pc_out_a, 32'h8);
    tick();
    chk("stream3_count", 32'(count_a), 32'd1);
    chk("stream3_pc", pc_out_a, 32'hC);
    tick();
    chk("stream4_count", 32'(count_a), 32'd1);
    chk("stream4_addr", imem_addr_a, 32'h10);
    deq_a = 1'b0;
    tick();
    chk("two_count", 32'(count_a), 32'd2);

    // Reset wins over redirect, fetch and dequeue
    rst_a = 1'b1; redirect_a = 1'b1; redirect_pc_a = 32'h200; deq_a = 1'b1;
    tick();
    chk("rstprio_addr", imem_addr_a, 32'h0);
    chk("rstprio_count", 32'(count_a), 32'd0);
    rst_a = 1'b0; redirect_a = 1'b0; deq_a = 1'b0; fetch_en_a = 1'b0;
    tick();

    // Wrap on the 8-bit instance
    fetch_en_b = 1'b1;
    tick(); tick(); tick(); tick();
    chk("wrap_full", 32'(full_b), 32'd1);
    chk("wrap_addr", 32'(imem_addr_b), 32'h08);
    chk("wrap_ins", ins_out_b, 32'hBBBB00F8);
    chk("wrap_pc", 32'(pc_out_b), 32'hFC);
    push_b(32'hBBBB00F8, 32'hFC);
    push_b(32'hBBBB00FC, 32'h00);
    push_b(32'hBBBB0000, 32'h04);
    push_b(32'hBBBB0004, 32'h08);
    fetch_en_b = 1'b0; deq_b = 1'b1;
    tick(); tick(); tick(); tick();
    chk("wrap_empty_count", 32'(count_b), 32'd0);
    chk("wrap_empty_valid", 32'(valid_b), 32'd0);
    deq_b = 1'b0; fetch_en_b = 1'b1;
    tick();
    chk("wrap_again_count", 32'(count_b), 32'd1);
    chk("wrap_again_ins", ins_out_b, 32'hBBBB0008);
    chk("wrap_again_pc", 32'(pc_out_b), 32'h0C);
    chk("wrap_again_addr", 32'(imem_addr_b), 32'h0C);
    fetch_en_b = 1'b0;
    tick();

    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL provide parameter XLEN, default 32, giving the PC and address width in bits.
REQ-002 The module SHALL provide parameter DEPTH, default 4, giving the instruction-buffer entry count (power of two, >= 2).
REQ-003 The module SHALL provide parameter RESET_PC, default 0, giving the fetch address loaded at reset.
REQ-004 The module SHALL provide parameter PC_STEP, default 4, giving the sequential PC increment.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port fetch_en, input, 1 bit: fetch permitted this cycle (global PC-write enable).
REQ-008 The module SHALL have port imem_addr, output, XLEN bits: instruction-memory address, equal to the fetch PC register.
REQ-009 The module SHALL have port imem_data, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-010 The module SHALL have port redirect, input, 1 bit: taken branch/jump; flushes the queue and reloads the fetch PC.
REQ-011 The module SHALL have port redirect_pc, input, XLEN bits: new fetch PC, sampled when redirect=1.
REQ-012 The module SHALL have port deq, input, 1 bit: decode consumes the head entry.
REQ-013 The module SHALL have port valid, output, 1 bit: head entry present (count != 0).
REQ-014 The module SHALL have port ins_out, output, 32 bits: head instruction word.
REQ-015 The module SHALL have port pc_out, output, XLEN bits: head entry's fetch address plus PC_STEP.
REQ-016 The module SHALL have port full, output, 1 bit: count == DEPTH.
REQ-017 The module SHALL have port count, output, $clog2(DEPTH)+1 bits: occupied entry count.

Function
REQ-018 The module SHALL, per entry, store {instruction, fetch address + PC_STEP}.
REQ-019 The module SHALL perform a push when fetch_en=1, redirect=0, and (full=0 or deq=1); the push writes {imem_data, imem_addr+PC_STEP} at the tail and advances the fetch PC by PC_STEP.
REQ-020 The module SHALL perform a pop when deq=1, valid=1, and redirect=0, advancing the head pointer.
REQ-021 The module SHALL ignore deq when valid=0 (no underflow; count stays 0).
REQ-022 The module SHALL, when full=1 and deq=0, neither push nor advance the fetch PC (no overflow, no lost fetch).
REQ-023 The module SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 The module SHALL, when redirect=1, next cycle set count=0 and head=tail, load the fetch PC with redirect_pc, and perform no push or pop, regardless of fetch_en and deq.
REQ-025 The module SHALL wrap head and tail pointers modulo DEPTH, and the fetch PC modulo 2^XLEN.
REQ-026 The module SHALL present a word fetched at cycle t on ins_out/pc_out at cycle t+1 when the queue was empty at t (1-cycle latency).
REQ-027 The module SHALL drive ins_out=0 (NOP) and pc_out=0 while valid=0; entry contents are don't-care.
REQ-028 The module SHALL drive ins_out, pc_out, valid, full, and count purely from registered state (no combinational path from deq, redirect, or imem_data).
REQ-029 The module SHALL, with fetch_en=0, hold the fetch PC while pops proceed normally.

Reset
REQ-030 The module SHALL, on rst=1 at a rising edge, set fetch PC=RESET_PC, head=tail=0, and count=0, giving valid=0, full=0, ins_out=0, pc_out=0, imem_addr=RESET_PC.
REQ-031 The module SHALL give rst priority over redirect, push, and pop, including mid-operation with a partially filled queue.

Verification
REQ-032 The bench SHALL verify reset with defaults: imem_addr=0x0, count=0; after release with fetch_en=1, deq=0 and imem_data=0xAAAA0000+addr, 4 cycles later full=1, count=4, imem_addr=0x10, ins_out=0xAAAA0000, pc_out=0x4.
REQ-033 The bench SHALL verify steady stream: with fetch_en=1 and deq=1 each cycle from empty, count stays 1, and pc_out steps 0x4, 0x8, 0xC with matching ins_out.
REQ-034 The bench SHALL verify full with simultaneous deq: at count=4, deq=1 and fetch_en=1 keep count=4, advance imem_addr by 4, and advance the head by one.
REQ-035 The bench SHALL verify redirect: at count=3, redirect=1, redirect_pc=0x100 and deq=1 give count=0, valid=0, imem_addr=0x100 next cycle; the cycle after, ins_out=mem[0x100] and pc_out=0x104.
REQ-036 The bench SHALL verify underflow and reset priority: deq=1 at count=0 keeps count=0; rst=1 together with redirect=1 (redirect_pc=0x200) at count=2 gives imem_addr=RESET_PC and count=0.
REQ-037 The bench SHALL verify wrap: with XLEN=8, RESET_PC=0xF8, and 4 pushes, pc_out sequence is 0xFC, 0x00, 0x04, 0x08, and pointers wrap after DEPTH pops.
